// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: ALU_Control access codes, FSM encoding, access sizes and
// small decode helpers shared by the memory stage and its lane aligner.
package mem_stage_pkg;

    // ALU_Control codes for memory operations (MIPS opcode values)
    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h23;
    localparam logic [5:0] ALU_LBU = 6'h24;
    localparam logic [5:0] ALU_LHU = 6'h25;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Anything that is not an explicit byte/half code is treated as a word.
    function automatic size_e decode_size(input logic [5:0] ctl);
        case (ctl)
            ALU_LB, ALU_LBU, ALU_SB: return SZ_BYTE;
            ALU_LH, ALU_LHU, ALU_SH: return SZ_HALF;
            ALU_LW, ALU_SW:          return SZ_WORD;
            default:                 return SZ_WORD;
        endcase
    endfunction

    function automatic logic decode_signed(input logic [5:0] ctl);
        return (ctl == ALU_LB) || (ctl == ALU_LH);
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane steering. Stores get
// replicated data plus byte enables; loads get the selected lane(s)
// sign- or zero-extended to 32 bits.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  size_e       size_i,
    input  logic        sign_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Lane select / replicate / extend by access size
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        wdata_o   = wdata_i;
        byte_en_o = 4'b1111;
        rdata_o   = rdata_i;
        lane8     = 8'(rdata_i >> {addr_lo_i, 3'b000});
        lane16    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                wdata_o   = {4{wdata_i[7:0]}};
                byte_en_o = 4'b0001 << addr_lo_i;
                rdata_o   = {{24{sign_i & lane8[7]}}, lane8};
            end
            SZ_HALF: begin
                wdata_o   = {2{wdata_i[15:0]}};
                byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                rdata_o   = {{16{sign_i & lane16[15]}}, lane16};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between execute and writeback.
// Issues req/ack accesses, stalls upstream while one is outstanding,
// abandons it after TIMEOUT wait cycles, and registers the WB result.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// trapped (no request, bubble, Misalign_OUT pulse, BadAddr_OUT latched).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    output logic [31:0] DMem_Addr,
    output logic [31:0] DMem_WData,
    output logic [3:0]  DMem_ByteEn,
    output logic        DMem_Req,
    output logic        DMem_Write,
    input  logic        DMem_Ack,
    input  logic [31:0] DMem_RData,
    output logic        Stall_OUT,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WB_result_OUT,
    output logic [4:0]  WBWriteReg_OUT,
    output logic        RegWrite1_OUT,
    output logic        DMem_Err
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        Misalign_OUT,
    output logic [31:0] BadAddr_OUT
`endif
);

    // The last WAIT cycle; its edge either completes (Ack) or times out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req, stall, timeout, bubble, mis_trap;
    logic        access, is_store, err_q;
    size_e       size;
    logic [31:0] wdata_rep, load_data;
    logic [3:0]  byte_en;

    // A load wins when both MemRead and MemWrite are set.
    assign access   = MemRead1_IN | MemWrite1_IN;
    assign is_store = MemWrite1_IN & ~MemRead1_IN;
    assign size     = decode_size(ALU_Control1_IN);

    mem_lane_align u_align (
        .size_i    (size),
        .sign_i    (decode_signed(ALU_Control1_IN)),
        .addr_lo_i (ALU_result1_IN[1:0]),
        .wdata_i   (MemWriteData1_IN),
        .rdata_i   (DMem_RData),
        .wdata_o   (wdata_rep),
        .byte_en_o (byte_en),
        .rdata_o   (load_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_trap = (state_q == ST_IDLE) & access
                    & is_misaligned(size, ALU_result1_IN[1:0]);
`else
    assign mis_trap = 1'b0;
`endif

    // Next-state, request, stall and timeout decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && !mis_trap) begin
                    req = 1'b1;
                    if (!DMem_Ack) begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (DMem_Ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TO_LAST) begin
                    // Stall already released so upstream moves past the access.
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bubble = stall | timeout | mis_trap;

    // Reset must silence the bus immediately, not at the next edge.
    assign DMem_Req    = req & ~RESET;
    assign DMem_Write  = DMem_Req & is_store;
    assign DMem_ByteEn = DMem_Req ? byte_en : 4'b0000;
    assign DMem_Addr   = {ALU_result1_IN[31:2], 2'b00};
    assign DMem_WData  = wdata_rep;
    assign Stall_OUT   = stall & ~RESET;
    assign DMem_Err    = err_q;

    // FSM state and wait counter registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= timeout;
        end
    end

    // Writeback pipeline register: bubble while stalled, trapped or timed out
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Instr1_OUT     <= 32'd0;
            Instr1_PC_OUT  <= 32'd0;
            WB_result_OUT  <= 32'd0;
            WBWriteReg_OUT <= 5'd0;
            RegWrite1_OUT  <= 1'b0;
        end else if (bubble) begin
            Instr1_OUT     <= 32'd0;
            Instr1_PC_OUT  <= 32'd0;
            WB_result_OUT  <= 32'd0;
            WBWriteReg_OUT <= 5'd0;
            RegWrite1_OUT  <= 1'b0;
        end else begin
            Instr1_OUT     <= Instr1_IN;
            Instr1_PC_OUT  <= Instr1_PC_IN;
            WB_result_OUT  <= MemRead1_IN ? load_data : ALU_result1_IN;
            WBWriteReg_OUT <= WriteRegister1_IN;
            RegWrite1_OUT  <= RegWrite1_IN & ~is_store;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalignment pulse and faulting-address capture
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Misalign_OUT <= 1'b0;
            BadAddr_OUT  <= 32'd0;
        end else begin
            Misalign_OUT <= mis_trap;
            if (mis_trap) begin
                BadAddr_OUT <= ALU_result1_IN;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage (TIMEOUT = 4) plus hand
// sequences for wait-state stores, timeout, async reset and, when
// MEM_MISALIGN_TRAP_EN is defined, the misalignment trap.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
    logic [4:0]  WriteRegister1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
    logic [5:0]  ALU_Control1_IN;
    logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
    logic [3:0]  DMem_ByteEn;
    logic        DMem_Req, DMem_Write, DMem_Ack, Stall_OUT, DMem_Err;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WB_result_OUT;
    logic [4:0]  WBWriteReg_OUT;
    logic        RegWrite1_OUT;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        Misalign_OUT;
    logic [31:0] BadAddr_OUT;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_stage #(.TIMEOUT(4)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr1_IN         (Instr1_IN),
        .Instr1_PC_IN      (Instr1_PC_IN),
        .ALU_result1_IN    (ALU_result1_IN),
        .WriteRegister1_IN (WriteRegister1_IN),
        .MemWriteData1_IN  (MemWriteData1_IN),
        .RegWrite1_IN      (RegWrite1_IN),
        .ALU_Control1_IN   (ALU_Control1_IN),
        .MemRead1_IN       (MemRead1_IN),
        .MemWrite1_IN      (MemWrite1_IN),
        .DMem_Addr         (DMem_Addr),
        .DMem_WData        (DMem_WData),
        .DMem_ByteEn       (DMem_ByteEn),
        .DMem_Req          (DMem_Req),
        .DMem_Write        (DMem_Write),
        .DMem_Ack          (DMem_Ack),
        .DMem_RData        (DMem_RData),
        .Stall_OUT         (Stall_OUT),
        .Instr1_OUT        (Instr1_OUT),
        .Instr1_PC_OUT     (Instr1_PC_OUT),
        .WB_result_OUT     (WB_result_OUT),
        .WBWriteReg_OUT    (WBWriteReg_OUT),
        .RegWrite1_OUT     (RegWrite1_OUT),
        .DMem_Err          (DMem_Err)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .Misalign_OUT      (Misalign_OUT),
        .BadAddr_OUT       (BadAddr_OUT)
`endif
    );

    typedef struct {
        logic [5:0]  ctl;
        logic        mr, mw, regw, ack;
        logic [31:0] alu, wdata, rdata;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_req, e_write;
        logic [31:0] e_result;
        logic        e_regw;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] ctl, input logic mr, mw, regw, ack,
                           input logic [31:0] alu, wdata, rdata, e_addr, e_wdata,
                           input logic [3:0] e_be, input logic e_req, e_write,
                           input logic [31:0] e_result, input logic e_regw);
        vec_t v;
        v.ctl = ctl; v.mr = mr; v.mw = mw; v.regw = regw; v.ack = ack;
        v.alu = alu; v.wdata = wdata; v.rdata = rdata;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be;
        v.e_req = e_req; v.e_write = e_write; v.e_result = e_result; v.e_regw = e_regw;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] instr, pc, alu, input logic [4:0] wreg,
                         input logic [31:0] wdata, input logic regw, input logic [5:0] ctl,
                         input logic mr, mw, ack, input logic [31:0] rdata);
        Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = alu;
        WriteRegister1_IN = wreg; MemWriteData1_IN = wdata; RegWrite1_IN = regw;
        ALU_Control1_IN = ctl; MemRead1_IN = mr; MemWrite1_IN = mw;
        DMem_Ack = ack; DMem_RData = rdata;
    endtask

    task automatic nop();
        drive(32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int  stall_cnt;
        bit  done;

        RESET = 1'b1;
        nop();

        // ctl  mr mw rw ack  alu  wdata  rdata  e_addr e_wdata e_be e_req e_wr e_result e_regw
        add_vec(6'h00, 0,0,1,0, 32'h0000_1234, 32'h0, 32'h0,
                32'h0000_1234, 32'h0, 4'b0000, 0,0, 32'h0000_1234, 1);
        add_vec(6'h20, 1,0,1,1, 32'h0000_0103, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 32'h0, 4'b1000, 1,0, 32'hFFFF_FF80, 1);
        add_vec(6'h24, 1,0,1,1, 32'h0000_0103, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 32'h0, 4'b1000, 1,0, 32'h0000_0080, 1);
        add_vec(6'h21, 1,0,1,1, 32'h0000_0202, 32'h0, 32'h8001_7FFF,
                32'h0000_0200, 32'h0, 4'b1100, 1,0, 32'hFFFF_8001, 1);
        add_vec(6'h25, 1,0,1,1, 32'h0000_0200, 32'h0, 32'h8001_F00D,
                32'h0000_0200, 32'h0, 4'b0011, 1,0, 32'h0000_F00D, 1);
        add_vec(6'h23, 1,0,1,1, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF,
                32'h0000_0404, 32'h0, 4'b1111, 1,0, 32'hDEAD_BEEF, 1);
        add_vec(6'h28, 0,1,1,1, 32'h0000_0501, 32'h1234_56AB, 32'h0,
                32'h0000_0500, 32'hABAB_ABAB, 4'b0010, 1,1, 32'h0000_0501, 0);
        add_vec(6'h2B, 0,1,0,1, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,
                32'h0000_0600, 32'hCAFE_F00D, 4'b1111, 1,1, 32'h0000_0600, 0);
        add_vec(6'h29, 0,1,1,1, 32'h0000_0610, 32'h0000_BEEF, 32'h0,
                32'h0000_0610, 32'hBEEF_BEEF, 4'b0011, 1,1, 32'h0000_0610, 0);
        add_vec(6'h23, 1,1,1,1, 32'h0000_0700, 32'h0, 32'h1122_3344,
                32'h0000_0700, 32'h0, 4'b1111, 1,0, 32'h1122_3344, 1);
`ifndef MEM_MISALIGN_TRAP_EN
        add_vec(6'h23, 1,0,1,1, 32'h0000_0703, 32'h0, 32'h5566_7788,
                32'h0000_0700, 32'h0, 4'b1111, 1,0, 32'h5566_7788, 1);
        add_vec(6'h21, 1,0,1,1, 32'h0000_0303, 32'h0, 32'h7ABC_0000,
                32'h0000_0300, 32'h0, 4'b1100, 1,0, 32'h0000_7ABC, 1);
`endif

        // Reset state
        #2;
        check("rst_req", {31'd0, DMem_Req}, 32'd0);
        check("rst_stall", {31'd0, Stall_OUT}, 32'd0);
        check("rst_result", WB_result_OUT, 32'd0);
        check("rst_regw", {31'd0, RegWrite1_OUT}, 32'd0);
        check("rst_err", {31'd0, DMem_Err}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_badaddr", BadAddr_OUT, 32'd0);
`endif
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // Table-driven single-cycle operations (zero-wait Ack)
        foreach (vecs[i]) begin
            drive(32'hA000_0000 | 32'(i), 32'h1000 + 32'(4 * i), vecs[i].alu, 5'(i + 1),
                  vecs[i].wdata, vecs[i].regw, vecs[i].ctl, vecs[i].mr, vecs[i].mw,
                  vecs[i].ack, vecs[i].rdata);
            @(negedge CLK);
            check($sformatf("v%0d_stall", i), {31'd0, Stall_OUT}, 32'd0);
            check($sformatf("v%0d_req", i), {31'd0, DMem_Req}, {31'd0, vecs[i].e_req});
            check($sformatf("v%0d_write", i), {31'd0, DMem_Write}, {31'd0, vecs[i].e_write});
            check($sformatf("v%0d_addr", i), DMem_Addr, vecs[i].e_addr);
            check($sformatf("v%0d_be", i), {28'd0, DMem_ByteEn}, {28'd0, vecs[i].e_be});
            if (vecs[i].e_write)
                check($sformatf("v%0d_wdata", i), DMem_WData, vecs[i].e_wdata);
            tick();
            check($sformatf("v%0d_result", i), WB_result_OUT, vecs[i].e_result);
            check($sformatf("v%0d_regw", i), {31'd0, RegWrite1_OUT}, {31'd0, vecs[i].e_regw});
            check($sformatf("v%0d_wreg", i), {27'd0, WBWriteReg_OUT}, 32'(i + 1));
            check($sformatf("v%0d_instr", i), Instr1_OUT, 32'hA000_0000 | 32'(i));
            check($sformatf("v%0d_pc", i), Instr1_PC_OUT, 32'h1000 + 32'(4 * i));
        end

        // SH with Ack after three stalled cycles
        drive(32'hB000_0001, 32'h2000, 32'h0000_0202, 5'd7, 32'h0000_ABCD, 1'b1,
              6'h29, 1'b0, 1'b1, 1'b0, 32'd0);
        stall_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            DMem_Ack = (c == 3);
            @(negedge CLK);
            check("sh_req", {31'd0, DMem_Req}, 32'd1);
            check("sh_wdata", DMem_WData, 32'hABCD_ABCD);
            check("sh_be", {28'd0, DMem_ByteEn}, 32'b1100);
            if (Stall_OUT) stall_cnt++;
            done = !Stall_OUT;
            tick();
            if (!done) begin
                check("sh_bubble_regw", {31'd0, RegWrite1_OUT}, 32'd0);
                check("sh_bubble_instr", Instr1_OUT, 32'd0);
            end
            if (done) break;
        end
        check("sh_done", {31'd0, done}, 32'd1);
        check("sh_stall_cycles", stall_cnt, 32'd3);
        check("sh_regw", {31'd0, RegWrite1_OUT}, 32'd0);
        check("sh_result", WB_result_OUT, 32'h0000_0202);
        check("sh_instr", Instr1_OUT, 32'hB000_0001);

        // LW that never gets Ack: timeout after four WAIT cycles
        drive(32'hC000_0001, 32'h3000, 32'h0000_0800, 5'd9, 32'd0, 1'b1,
              6'h23, 1'b1, 1'b0, 1'b0, 32'd0);
        stall_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check("to_req", {31'd0, DMem_Req}, 32'd1);
            check("to_err_low", {31'd0, DMem_Err}, 32'd0);
            if (Stall_OUT) stall_cnt++;
            done = !Stall_OUT;
            tick();
            if (done) break;
        end
        check("to_done", {31'd0, done}, 32'd1);
        check("to_stall_cycles", stall_cnt, 32'd4);
        check("to_err_pulse", {31'd0, DMem_Err}, 32'd1);
        check("to_bubble_regw", {31'd0, RegWrite1_OUT}, 32'd0);
        check("to_bubble_instr", Instr1_OUT, 32'd0);
        nop();
        @(negedge CLK);
        check("to_req_dropped", {31'd0, DMem_Req}, 32'd0);
        tick();
        check("to_err_end", {31'd0, DMem_Err}, 32'd0);
        drive(32'hC000_0002, 32'h3004, 32'h0000_0804, 5'd10, 32'd0, 1'b1,
              6'h23, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
        @(negedge CLK);
        check("to_idle_stall", {31'd0, Stall_OUT}, 32'd0);
        tick();
        check("to_idle_result", WB_result_OUT, 32'h0BAD_F00D);

        // Asynchronous reset while waiting
        drive(32'hD000_0001, 32'h4000, 32'h0000_0900, 5'd3, 32'd0, 1'b1,
              6'h23, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        #2;
        RESET = 1'b1;
        #1;
        check("arst_req", {31'd0, DMem_Req}, 32'd0);
        check("arst_stall", {31'd0, Stall_OUT}, 32'd0);
        check("arst_result", WB_result_OUT, 32'd0);
        check("arst_regw", {31'd0, RegWrite1_OUT}, 32'd0);
        drive(32'hD000_0002, 32'h4004, 32'h0000_0A00, 5'd4, 32'd0, 1'b1,
              6'h23, 1'b1, 1'b0, 1'b1, 32'h1357_9BDF);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("arst_new_stall", {31'd0, Stall_OUT}, 32'd0);
        check("arst_new_req", {31'd0, DMem_Req}, 32'd1);
        tick();
        check("arst_new_result", WB_result_OUT, 32'h1357_9BDF);
        check("arst_new_wreg", {27'd0, WBWriteReg_OUT}, 32'd4);
        check("arst_new_regw", {31'd0, RegWrite1_OUT}, 32'd1);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word load is trapped
        drive(32'hE000_0001, 32'h5000, 32'h0000_0301, 5'd6, 32'd0, 1'b1,
              6'h23, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("mis_req", {31'd0, DMem_Req}, 32'd0);
        check("mis_stall", {31'd0, Stall_OUT}, 32'd0);
        tick();
        check("mis_pulse", {31'd0, Misalign_OUT}, 32'd1);
        check("mis_badaddr", BadAddr_OUT, 32'h0000_0301);
        check("mis_regw", {31'd0, RegWrite1_OUT}, 32'd0);
        nop();
        tick();
        check("mis_pulse_end", {31'd0, Misalign_OUT}, 32'd0);
        check("mis_badaddr_held", BadAddr_OUT, 32'h0000_0301);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its registered outputs (ALU result, destination register, store data, RegWrite, ALU control, MemRead/MemWrite).
- Performs data-memory loads and stores over a req/ack handshake, with byte/half/word lane steering and sign/zero extension.
- Stalls upstream while an access is outstanding; registers the result into the writeback pipeline register, which also drives the execute stage's WB forwarding inputs.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before the access is abandoned; valid range 1..255.

Ports:
- CLK  input  1  stage clock, posedge.
- RESET  input  1  asynchronous, active-high reset.
- Instr1_IN  input  32  instruction (debug), passed through.
- Instr1_PC_IN  input  32  PC (debug), passed through.
- ALU_result1_IN  input  32  effective address, or result for non-memory ops.
- WriteRegister1_IN  input  5  destination register.
- MemWriteData1_IN  input  32  store data.
- RegWrite1_IN  input  1  instruction writes a register.
- ALU_Control1_IN  input  6  selects access size/sign (codes in package).
- MemRead1_IN  input  1  load.
- MemWrite1_IN  input  1  store.
- DMem_Addr  output  32  word-aligned address {addr[31:2],2'b00}.
- DMem_WData  output  32  lane-replicated store data.
- DMem_ByteEn  output  4  byte enables.
- DMem_Req  output  1  access request.
- DMem_Write  output  1  1 = store.
- DMem_Ack  input  1  access complete; RData valid same cycle.
- DMem_RData  input  32  read word.
- Stall_OUT  output  1  hold upstream stages.
- Instr1_OUT, Instr1_PC_OUT  output  32  to WB.
- WB_result_OUT  output  32  load data or pass-through ALU result.
- WBWriteReg_OUT  output  5  to WB and execute forwarding.
- RegWrite1_OUT  output  1  to WB.
- DMem_Err  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all registered outputs 0, FSM to IDLE, timeout counter 0. Reset asserted mid-access drops DMem_Req immediately (async) and discards the access.
- FSM states IDLE and WAIT. Access = MemRead1_IN | MemWrite1_IN; if both are set, the load wins.
- IDLE, no access: inputs registered to WB outputs on the next edge; WB_result_OUT = ALU_result1_IN. Latency 1.
- IDLE, access:
  - DMem_Req asserted combinationally in the same cycle.
  - If DMem_Ack is also high (zero-wait), complete at that edge and stay in IDLE; Stall_OUT = 0.
  - Otherwise Stall_OUT = 1 and go to WAIT.
- WAIT:
  - DMem_Req, Addr, WData, ByteEn and Write are held from the inputs; upstream holds them stable because of the stall.
  - Stall_OUT = 1 until the Ack cycle; on Ack, Stall_OUT = 0, the result is registered, and the FSM returns to IDLE.
- Bubbles: every edge where Stall_OUT = 1 registers a bubble to WB (RegWrite1_OUT = 0, Instr1_OUT = 0).
- Lanes (little-endian): byte k occupies bits 8k+7:8k, k = addr[1:0].
  - SB: data[7:0] replicated x4, ByteEn = 1<<k.
  - SH: data[15:0] replicated x2, ByteEn = addr[1] ? 4'b1100 : 4'b0011.
  - SW: ByteEn = 4'b1111.
  - Loads: select lane(s); LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Stores complete with RegWrite1_OUT forced 0 and WB_result_OUT = ALU_result1_IN.
- Timeout:
  - The counter increments each cycle in WAIT. On reaching TIMEOUT without Ack: DMem_Err pulses, DMem_Req drops, a bubble goes to WB, FSM returns to IDLE and Stall_OUT drops.
  - Ack on the same cycle as the counter reaching TIMEOUT counts as success.
  - The counter clears on leaving WAIT.
- Misalignment (feature off): ignored; addr[0] is dropped for halfwords, addr[1:0] for words.

Optional Feature:
- MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no request.
  - Adds outputs Misalign_OUT (1-cycle pulse) and BadAddr_OUT[31:0] (latched address, reset 0).
  - A bubble is sent to WB and there is no stall.
- Undefined: those ports are absent and misaligned accesses are truncated as described under Behaviour.

Decomposition:
- Shared package holds:
  - ALU_Control codes: LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B (MIPS opcode values).
  - FSM state encoding.
  - Access-size enum.
- Sub-module mem_lane_align: purely combinational byte-enable/replication for stores and extraction/extension for loads, shared by both paths.

Test Plan:
- ALU op, RegWrite=1, result 0x00001234 to reg 5, no access -> next edge WB_result_OUT=0x00001234, WBWriteReg_OUT=5, Stall_OUT never 1.
- LB addr 0x103, RData 0x80FF_1234, Ack same cycle -> WB_result_OUT=0xFFFFFF80, DMem_Addr=0x100, zero stall cycles; LBU same stimulus -> 0x00000080.
- SH addr 0x202, data 0x0000ABCD, Ack after 3 cycles -> DMem_WData=0xABCDABCD, ByteEn=1100, Stall_OUT high 3 cycles, 3 bubbles then store completes with RegWrite1_OUT=0.
- LW with Ack never asserted, TIMEOUT=4 -> DMem_Err pulses after 4 WAIT cycles, Req drops, bubble to WB, FSM back to IDLE.
- RESET asserted while in WAIT -> Req and all outputs 0 immediately; after release, a new LW completes normally.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x301 -> DMem_Req stays 0, Misalign_OUT pulse, BadAddr_OUT=0x301, RegWrite1_OUT=0.
